lock_sequencer: RTL and testbench

Initiator side of the lockable-register interface. Accepts a stream of (address, data) programming commands over a valid/ready handshake and writes each command into one of NUM_REGS lockable config registers. It reads each register back to verify the write. After the last command, it broadcasts a one-cycle lock pulse so the bank is frozen until reset. It sits between the boot/config fetch engine and the lockable register bank.

---
 rtl/lock_seq_pkg.sv | 20 ++
 rtl/lock_seq_rb_mux.sv | 23 ++
 rtl/lock_sequencer.sv | 142 ++++++++++++++
 tb/tb_lock_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_seq_pkg.sv
// Shared types for the lock sequencer: FSM states and error codes.
package lock_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StVerify,
    StLock,
    StDone,
    StError
  } lock_state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE       = 2'd0;
  localparam err_code_t ERR_BAD_ADDR   = 2'd1;
  localparam err_code_t ERR_MISMATCH   = 2'd2;
  localparam err_code_t ERR_INCOMPLETE = 2'd3;

endpackage

// File: rtl/lock_seq_rb_mux.sv
// Readback slice select and compare against the value just written.
module lock_seq_rb_mux #(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          expected,
  output logic                       match
);

  logic [DATA_W-1:0] rdata_sel;

  always_comb begin
    rdata_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(addr) == i) rdata_sel = reg_rdata[i*DATA_W +: DATA_W];
    end
    match = (rdata_sel == expected);
  end

endmodule

// File: rtl/lock_sequencer.sv
// Programs, verifies and then locks a bank of config registers.
// Define LOCK_SEQ_LOCK_ON_ERROR_EN to also lock the bank when the sequence aborts.
module lock_sequencer
  import lock_seq_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [DATA_W-1:0]          cmd_data,
  input  logic                       cmd_last,
  output logic [DATA_W-1:0]          reg_data,
  output logic [NUM_REGS-1:0]        reg_wr_en,
  output logic                       reg_lock_en,
  input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [1:0]                 err_code,
  output logic [ADDR_W-1:0]          err_addr
);

  lock_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic                lock_q, lock_d;
  err_code_t           err_code_q, err_code_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic                match;

  lock_seq_rb_mux #(
    .NUM_REGS(NUM_REGS),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) u_rb_mux (
    .reg_rdata(reg_rdata),
    .addr     (addr_q),
    .expected (data_q),
    .match    (match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      mask_q     <= '0;
      wr_en_q    <= '0;
      lock_q     <= 1'b0;
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      mask_q     <= mask_d;
      wr_en_q    <= wr_en_d;
      lock_q     <= lock_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    last_d     = last_q;
    mask_d     = mask_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          last_d = cmd_last;
          if (32'(cmd_addr) >= NUM_REGS) begin
            state_d    = StError;
            err_code_d = ERR_BAD_ADDR;
            err_addr_d = cmd_addr;
          end else begin
            state_d = StWrite;
            data_d  = cmd_data;
          end
        end
      end
      StWrite: state_d = StVerify;
      StVerify: begin
        if (!match) begin
          state_d    = StError;
          err_code_d = ERR_MISMATCH;
          err_addr_d = addr_q;
        end else begin
          mask_d = mask_q | (NUM_REGS'(1) << addr_q);
          if (!last_q) begin
            state_d = StIdle;
          end else if (&mask_d) begin
            state_d = StLock;
          end else begin
            state_d    = StError;
            err_code_d = ERR_INCOMPLETE;
            err_addr_d = '0;
          end
        end
      end
      StLock:  state_d = StDone;
      StDone:  state_d = StDone;
      StError: state_d = StError;
      default: state_d = StIdle;
    endcase

    // Strobes are computed from the next state so they come straight off flops.
    wr_en_d = (state_d == StWrite) ? (NUM_REGS'(1) << addr_d) : '0;
    lock_d  = (state_d == StLock);
`ifdef LOCK_SEQ_LOCK_ON_ERROR_EN
    lock_d  = lock_d | ((state_d == StError) && (state_q != StError));
`endif
  end

  always_comb begin
    cmd_ready   = (state_q == StIdle);
    busy        = (state_q == StWrite) || (state_q == StVerify) || (state_q == StLock);
    done        = (state_q == StDone);
    error       = (state_q == StError);
    reg_data    = data_q;
    reg_wr_en   = wr_en_q;
    reg_lock_en = lock_q;
    err_code    = err_code_q;
    err_addr    = err_addr_q;
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed self-checking bench for lock_sequencer with a small model register bank.
module tb_lock_sequencer;

`ifdef LOCK_SEQ_LOCK_ON_ERROR_EN
  localparam int LockOnErr = 1;
`else
  localparam int LockOnErr = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_addr = '0;
  logic [7:0]  cmd_data = '0;
  logic        cmd_last = 1'b0;
  logic [7:0]  reg_data;
  logic [3:0]  reg_wr_en;
  logic        reg_lock_en;
  logic [31:0] reg_rdata;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [3:0]  err_addr;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int lock_cnt = 0;
  int viol = 0;
  int strobe_cyc[$];

  logic [7:0] bank [4];
  logic       bank_locked;
  logic       force2 = 1'b0;

  lock_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_last   (cmd_last),
    .reg_data   (reg_data),
    .reg_wr_en  (reg_wr_en),
    .reg_lock_en(reg_lock_en),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model lockable bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) bank[i] <= '0;
      bank_locked <= 1'b0;
    end else if (reg_lock_en) begin
      bank_locked <= 1'b1;
    end else if (!bank_locked) begin
      for (int i = 0; i < 4; i++) if (reg_wr_en[i]) bank[i] <= reg_data;
    end
  end

  assign reg_rdata = {bank[3], force2 ? 8'h00 : bank[2], bank[1], bank[0]};

  always @(negedge clk) begin
    if (reg_wr_en != 4'b0) begin
      wr_cnt++;
      strobe_cyc.push_back(cyc);
    end
    if (reg_lock_en) lock_cnt++;
    if ($countones(reg_wr_en) > 1 || (reg_wr_en != 4'b0 && reg_lock_en)) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge of the WRITE cycle.
  task automatic send(input logic [3:0] a, input logic [7:0] d, input logic l);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_last  = l;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("send_timeout", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_full(input string tag);
    int lc;
    strobe_cyc.delete();
    send(4'd0, 8'hA5, 1'b0);
    check({tag, "_wr0"}, 32'(reg_wr_en), 32'h1);
    check({tag, "_data0"}, 32'(reg_data), 32'hA5);
    send(4'd1, 8'h3C, 1'b0);
    send(4'd2, 8'hFF, 1'b0);
    send(4'd3, 8'h01, 1'b1);
    check({tag, "_wr3"}, 32'(reg_wr_en), 32'h8);
    lc = lock_cnt;
    @(negedge clk);
    check({tag, "_verify_nolock"}, 32'(reg_lock_en), 32'd0);
    @(negedge clk);
    check({tag, "_lock"}, 32'(reg_lock_en), 32'd1);
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_lockcnt"}, 32'(lock_cnt - lc), 32'd1);
    check({tag, "_nstrobe"}, 32'(strobe_cyc.size()), 32'd4);
    if (strobe_cyc.size() == 4)
      for (int i = 0; i < 3; i++)
        check({tag, "_spacing"}, 32'(strobe_cyc[i+1] - strobe_cyc[i]), 32'd3);
    check({tag, "_bank"}, {bank[3], bank[2], bank[1], bank[0]}, 32'h01FF3CA5);
  endtask

  initial begin
    int wc, lc, lows;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr", 32'(reg_wr_en), 32'd0);
    check("rst_lock", 32'(reg_lock_en), 32'd0);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);
    check("rst_err", {26'd0, err_code, err_addr}, 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Full sequence, then hammer cmd_valid after done
    run_full("seq");
    wc = wr_cnt;
    lc = lock_cnt;
    lows = 0;
    cmd_valid = 1'b1;
    cmd_addr  = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ready) lows++;
    end
    cmd_valid = 1'b0;
    check("post_done_ready", 32'(lows), 32'd0);
    check("post_done_wr", 32'(wr_cnt - wc), 32'd0);
    check("post_done_lock", 32'(lock_cnt - lc), 32'd0);
    check("post_done_done", 32'(done), 32'd1);

    // Bad address
    do_reset();
    wc = wr_cnt;
    lc = lock_cnt;
    send(4'd5, 8'h11, 1'b0);
    check("bad_error", 32'(error), 32'd1);
    check("bad_code", 32'(err_code), 32'd1);
    check("bad_addr", 32'(err_addr), 32'd5);
    check("bad_done", 32'(done), 32'd0);
    check("bad_busy", 32'(busy), 32'd0);
    check("bad_lock_now", 32'(reg_lock_en), 32'(LockOnErr));
    repeat (5) @(negedge clk);
    check("bad_wr", 32'(wr_cnt - wc), 32'd0);
    check("bad_lockcnt", 32'(lock_cnt - lc), 32'(LockOnErr));

    // Readback mismatch on register 2
    do_reset();
    force2 = 1'b1;
    lc = lock_cnt;
    send(4'd2, 8'h77, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("mm_code", 32'(err_code), 32'd2);
    check("mm_addr", 32'(err_addr), 32'd2);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (!error || err_code != 2'd2) lows++;
      @(negedge clk);
    end
    check("mm_sticky", 32'(lows), 32'd0);
    check("mm_lockcnt", 32'(lock_cnt - lc), 32'(LockOnErr));
    force2 = 1'b0;

    // Incomplete bank
    do_reset();
    lc = lock_cnt;
    send(4'd0, 8'h10, 1'b0);
    send(4'd1, 8'h20, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("inc_error", 32'(error), 32'd1);
    check("inc_code", 32'(err_code), 32'd3);
    check("inc_addr", 32'(err_addr), 32'd0);
    check("inc_lockcnt", 32'(lock_cnt - lc), 32'(LockOnErr));

    // Reset during the second WRITE
    do_reset();
    lc = lock_cnt;
    send(4'd0, 8'h55, 1'b0);
    send(4'd1, 8'h66, 1'b0);
    check("mid_wr", 32'(reg_wr_en), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr", 32'(reg_wr_en), 32'd0);
    check("mid_rst_data", 32'(reg_data), 32'd0);
    check("mid_rst_flags", {28'd0, reg_lock_en, busy, done, error}, 32'd0);
    check("mid_rst_err", {26'd0, err_code, err_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_ready", 32'(cmd_ready), 32'd1);
    check("mid_nolock", 32'(lock_cnt - lc), 32'd0);
    run_full("rerun");

    check("strobe_rules", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
